// File: rtl/elem_pkg.sv
// Shared widths and types for the one-hot element datapath.
package elem_pkg;
   localparam int ELEM_W = 16;
   localparam int IDX_W  = 4;

   typedef logic [ELEM_W-1:0] elem_onehot_t;

   typedef struct packed {
      elem_onehot_t onehot;
      logic         err;
   } elem_entry_t;
endpackage

// File: rtl/onehot_decoder.sv
// Combinational binary index -> one-hot element vector with out-of-range flag.
module onehot_decoder
   import elem_pkg::*;
(
   input  logic [ELEM_W-1:0] data,
   output elem_entry_t       entry
);
   logic         in_range;
   elem_onehot_t onehot;

   // Any set bit above the index field (including the sign bit) is out of range.
   assign in_range = (data[ELEM_W-1:IDX_W] == '0);

   generate
      for (genvar gi = 0; gi < ELEM_W; gi++) begin : g_bit
         assign onehot[gi] = in_range && (data[IDX_W-1:0] == IDX_W'(gi));
      end
   endgenerate

   assign entry = {onehot, !in_range};
endmodule

// File: rtl/element_decode.sv
// Stream decoder: binary index words in, one-hot vectors out through a small FIFO,
// with a saturating count of rejected words.
module element_decode
   import elem_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ELEM_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ELEM_W-1:0] out_onehot,
   output logic              out_err,
   output logic [CNT_W-1:0]  err_count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_FW = $clog2(DEPTH + 1);

   elem_entry_t       mem_reg [DEPTH];
   elem_entry_t       dec_entry;
   elem_entry_t       head;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_FW-1:0] count_reg;
   logic [CNT_W-1:0]  err_count_reg;
   logic              push;
   logic              pop;

   onehot_decoder u_dec (
      .data  (in_data),
      .entry (dec_entry)
   );

   // in_ready depends only on the registered count, so a pop never frees a slot
   // for a push in the same cycle.
   assign in_ready  = (count_reg != CNT_FW'(DEPTH));
   assign out_valid = (count_reg != '0);
   assign push      = in_valid && in_ready && !rst;
   assign pop       = out_valid && out_ready && !rst;

   assign head       = mem_reg[rd_ptr_reg];
   assign out_onehot = out_valid ? head.onehot : '0;
   assign out_err    = out_valid && head.err;
   assign err_count  = err_count_reg;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= dec_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         err_count_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_FW'(1);
            2'b01:   count_reg <= count_reg - CNT_FW'(1);
            default: count_reg <= count_reg;
         endcase
         if (push && dec_entry.err && (err_count_reg != '1)) begin
            err_count_reg <= err_count_reg + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_element_decode.sv
// Self-checking bench for element_decode: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_element_decode;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_onehot;
   logic        out_err;
   logic [7:0]  err_count;

   int passed = 0;
   int total  = 0;

   // Reference model: queue of {onehot, err} entries and an error tally.
   logic [16:0] q[$];
   int          errcnt_m;

   element_decode #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_onehot (out_onehot),
      .out_err    (out_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [16:0] ref_decode(input logic [15:0] d);
      int unsigned v;
      v = d;
      if (v <= 15) return {16'(1 << v), 1'b0};
      return {16'h0000, 1'b1};
   endfunction

   task automatic check_outputs(input string tag);
      logic [16:0] head;
      head = (q.size() != 0) ? q[0] : 17'h0;
      chk({tag, ".out_valid"},  32'(out_valid),  32'(q.size() != 0));
      chk({tag, ".out_onehot"}, 32'(out_onehot), 32'(head[16:1]));
      chk({tag, ".out_err"},    32'(out_err),    32'(head[0]));
      chk({tag, ".in_ready"},   32'(in_ready),   32'(q.size() != DEPTH));
      chk({tag, ".err_count"},  32'(err_count),  32'(errcnt_m));
   endtask

   // One clock: check current outputs, drive inputs, advance model and DUT.
   task automatic cycle(input string tag, input logic v, input logic [15:0] d, input logic ordy);
      logic acc, pp;
      logic [16:0] e;
      check_outputs(tag);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      acc = v && (q.size() < DEPTH);
      pp  = ordy && (q.size() > 0);
      e   = ref_decode(d);
      if (pp) void'(q.pop_front());
      if (acc) begin
         q.push_back(e);
         if (e[0] && errcnt_m != 255) errcnt_m++;
      end
      step();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom_range(0, 31));
      out_ready = 1'($urandom_range(0, 1));
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      q.delete();
      errcnt_m = 0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      errcnt_m = 0;
      step(); step();
      rst = 1'b0;

      // Reset then idle
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.out_onehot", 32'(out_onehot), 32'h0);
      chk("reset.err_count", 32'(err_count), 32'd0);
      cycle("idle", 1'b0, 16'd0, 1'b0);

      // Single word, one-cycle latency
      cycle("w5", 1'b1, 16'd5, 1'b1);
      chk("w5.onehot", 32'(out_onehot), 32'h0020);
      cycle("w5pop", 1'b0, 16'd0, 1'b1);
      chk("w5.popped", 32'(out_valid), 32'd0);

      // Back-pressure: fill, stall, then drain in order
      cycle("bp0", 1'b1, 16'd0, 1'b0);
      cycle("bp15", 1'b1, 16'd15, 1'b0);
      chk("bp.full_ready", 32'(in_ready), 32'd0);
      cycle("bp3stall", 1'b1, 16'd3, 1'b0);
      chk("bp.head0", 32'(out_onehot), 32'h0001);
      cycle("bp3full", 1'b1, 16'd3, 1'b1);
      chk("bp.head15", 32'(out_onehot), 32'h8000);
      cycle("bp3acc", 1'b1, 16'd3, 1'b1);
      cycle("bp.drain", 1'b0, 16'd0, 1'b0);
      chk("bp.head3", 32'(out_onehot), 32'h0008);
      cycle("bp.pop", 1'b0, 16'd0, 1'b1);

      // Out-of-range words
      cycle("e16", 1'b1, 16'd16, 1'b1);
      chk("e16.err", 32'(out_err), 32'd1);
      cycle("effff", 1'b1, 16'hFFFF, 1'b1);
      chk("effff.err", 32'(out_err), 32'd1);
      chk("err2", 32'(err_count), 32'd2);
      cycle("epop", 1'b0, 16'd0, 1'b1);

      // Saturation
      for (int i = 0; i < 253; i++) cycle("sat", 1'b1, 16'd20, 1'b1);
      chk("sat.255", 32'(err_count), 32'd255);
      cycle("sat.extra", 1'b1, 16'd20, 1'b1);
      chk("sat.hold", 32'(err_count), 32'd255);
      cycle("sat.pop", 1'b0, 16'd0, 1'b1);

      // Reset while full discards entries
      cycle("f1", 1'b1, 16'd1, 1'b0);
      cycle("f2", 1'b1, 16'd2, 1'b0);
      chk("full.ready", 32'(in_ready), 32'd0);
      do_reset();
      chk("rstmid.out_valid", 32'(out_valid), 32'd0);
      chk("rstmid.err_count", 32'(err_count), 32'd0);
      chk("rstmid.in_ready", 32'(in_ready), 32'd1);
      cycle("rstmid.idle", 1'b0, 16'd0, 1'b1);

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] d;
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            d = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            cycle("rand", 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
         end
      end
      check_outputs("final");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
